exec_unit: RTL

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/exec_unit_if.sv | 30 +++
 rtl/exec_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/exec_unit_if.sv
// Fetch/decode handshake bundle: the exec unit requests with en/pc and the
// decoder answers with control_bus/data qualified by the IS_ready level.
interface exec_unit_if #(
    parameter int unsigned INST_CAP = 20,
    parameter int unsigned DATA_LEN = 8
);
    localparam int unsigned PC_W = $clog2(INST_CAP) + 1;

    logic [3:0]          control_bus;
    logic [DATA_LEN-1:0] data;
    logic                IS_ready;
    logic                en;
    logic [PC_W-1:0]     pc;

    modport master (
        output en,
        output pc,
        input  control_bus,
        input  data,
        input  IS_ready
    );

    modport slave (
        input  en,
        input  pc,
        output control_bus,
        output data,
        output IS_ready
    );
endinterface

// File: rtl/exec_unit.sv
// Accumulator execution unit: fetches one instruction per REQ/WLO/WHI handshake
// and applies it in a single EXEC cycle against a small local data memory.
module exec_unit #(
    parameter int unsigned INST_CAP = 20,
    parameter int unsigned DATA_LEN = 8,
    parameter int unsigned DATA_CAP = 16
) (
    input  logic                clk,
    input  logic                rstn,
    exec_unit_if.master         bus,
    output logic [DATA_LEN-1:0] acc,
    output logic                zf,
    output logic                cf,
    output logic                halted,
    output logic                err
);
    localparam int unsigned PC_W   = $clog2(INST_CAP) + 1;
    localparam int unsigned ADDR_W = $clog2(DATA_CAP);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(INST_CAP - 1);

    typedef enum logic [2:0] {StRst, StReq, StWlo, StWhi, StExec, StHalt} state_e;

    typedef enum logic [3:0] {
        OpLoad = 4'h0, OpStore = 4'h1, OpAdd = 4'h2, OpSub = 4'h3,
        OpAnd  = 4'h4, OpOr    = 4'h5, OpLdi = 4'h6, OpJmp = 4'h7,
        OpNop  = 4'h8, OpJz    = 4'h9, OpJc  = 4'ha, OpNot = 4'hb,
        OpShl  = 4'hc, OpShr   = 4'hd, OpHlt = 4'he, OpRsv = 4'hf
    } op_e;

    state_e              state_q, state_d;
    op_e                 op_q;
    logic [DATA_LEN-1:0] imm_q;
    logic                capture;

    logic [PC_W-1:0]     pc_q, pc_d;
    logic [DATA_LEN-1:0] acc_q, acc_d;
    logic                zf_q, zf_d, cf_q, cf_d, err_q, err_d;

    logic [DATA_LEN-1:0] dmem [DATA_CAP];
    logic [ADDR_W-1:0]   addr;
    logic [DATA_LEN-1:0] mem_rd;
    logic                mem_we;

    logic [DATA_LEN:0]   wide;
    logic [DATA_LEN-1:0] res;
    logic                acc_wr, taken;

    assign addr   = imm_q[ADDR_W-1:0];
    assign mem_rd = dmem[addr];

    // Handshake sequencing; IS_ready must be seen low before a new capture so a
    // stale answer for the previous pc is never executed twice.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            StRst:  state_d = StReq;
            StReq:  state_d = StWlo;
            StWlo:  if (!bus.IS_ready) state_d = StWhi;
            StWhi: begin
                if (bus.IS_ready) begin
                    state_d = StExec;
                    capture = 1'b1;
                end
            end
            StExec: state_d = (op_q == OpHlt) ? StHalt : StReq;
            StHalt: state_d = StHalt;
            default: state_d = StRst;
        endcase
    end

    always_comb begin
        pc_d   = pc_q;
        acc_d  = acc_q;
        zf_d   = zf_q;
        cf_d   = cf_q;
        err_d  = err_q;
        mem_we = 1'b0;
        wide   = '0;
        res    = acc_q;
        acc_wr = 1'b0;
        taken  = 1'b0;
        if (state_q == StExec) begin
            case (op_q)
                OpLoad:  begin res = mem_rd; acc_wr = 1'b1; end
                OpStore: mem_we = 1'b1;
                OpAdd: begin
                    wide   = {1'b0, acc_q} + {1'b0, mem_rd};
                    res    = wide[DATA_LEN-1:0];
                    cf_d   = wide[DATA_LEN];
                    acc_wr = 1'b1;
                end
                OpSub: begin
                    // Top bit of the widened difference is the borrow.
                    wide   = {1'b0, acc_q} - {1'b0, mem_rd};
                    res    = wide[DATA_LEN-1:0];
                    cf_d   = wide[DATA_LEN];
                    acc_wr = 1'b1;
                end
                OpAnd:   begin res = acc_q & mem_rd; acc_wr = 1'b1; end
                OpOr:    begin res = acc_q | mem_rd; acc_wr = 1'b1; end
                OpLdi:   begin res = imm_q; acc_wr = 1'b1; end
                OpJmp:   taken = 1'b1;
                OpJz:    taken = zf_q;
                OpJc:    taken = cf_q;
                OpNot:   begin res = ~acc_q; acc_wr = 1'b1; end
                OpShl: begin
                    cf_d   = acc_q[DATA_LEN-1];
                    res    = acc_q << 1;
                    acc_wr = 1'b1;
                end
                OpShr: begin
                    cf_d   = acc_q[0];
                    res    = acc_q >> 1;
                    acc_wr = 1'b1;
                end
                default: ;
            endcase

            if (acc_wr) begin
                acc_d = res;
                zf_d  = (res == '0);
            end

            // HLT takes the sequential path too, so a halted pc points past it.
            if (taken) begin
                if (32'(imm_q) >= INST_CAP) begin
                    pc_d  = '0;
                    err_d = 1'b1;
                end else begin
                    pc_d = PC_W'(imm_q);
                end
            end else if (pc_q == PC_LAST) begin
                pc_d = '0;
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StRst;
            op_q    <= OpNop;
            imm_q   <= '0;
            pc_q    <= '0;
            acc_q   <= '0;
            zf_q    <= 1'b1;
            cf_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            zf_q    <= zf_d;
            cf_q    <= cf_d;
            err_q   <= err_d;
            if (capture) begin
                op_q  <= op_e'(bus.control_bus);
                imm_q <= bus.data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) dmem[addr] <= acc_q;
    end

    assign bus.en = (state_q == StReq);
    assign bus.pc = pc_q;
    assign acc    = acc_q;
    assign zf     = zf_q;
    assign cf     = cf_q;
    assign err    = err_q;
    assign halted = (state_q == StHalt);
endmodule
